// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver.
//   - ps2_state_t : deframe FSM states
//   - prefix / drop-list scancode constants
//   - bit positions inside the 11-bit ps2_key event word
//   - is_drop()   : bytes that are keyboard status replies, not keys
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   // Controller replies (error, BAT ok, echo, ack, BAT fail, resend, error)
   localparam logic [7:0] DROP_00 = 8'h00;
   localparam logic [7:0] DROP_AA = 8'hAA;
   localparam logic [7:0] DROP_EE = 8'hEE;
   localparam logic [7:0] DROP_FA = 8'hFA;
   localparam logic [7:0] DROP_FC = 8'hFC;
   localparam logic [7:0] DROP_FE = 8'hFE;
   localparam logic [7:0] DROP_FF = 8'hFF;

   localparam int KEY_CODE_LSB = 0;
   localparam int KEY_CODE_MSB = 7;
   localparam int KEY_EXT      = 8;
   localparam int KEY_PRESS    = 9;
   localparam int KEY_TOGGLE   = 10;

   function automatic logic is_drop(input logic [7:0] b);
      return (b == DROP_00) || (b == DROP_AA) || (b == DROP_EE) ||
             (b == DROP_FA) || (b == DROP_FC) || (b == DROP_FE) ||
             (b == DROP_FF);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus a run-length glitch filter for the
// PS/2 clock line. The filtered level only changes after FILTER_LEN
// consecutive synced samples disagree with it; o_fall is a registered
// one-cycle pulse on each filtered 1->0 transition.
// Ports:
//   i_clk, i_rst : system clock, asynchronous active-high reset
//   i_raw        : raw asynchronous pin level
//   o_fall       : one-cycle pulse, filtered falling edge
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic          r_s0;
   logic          r_s1;
   logic          r_level;
   logic          r_level_q;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s0      <= 1'b1;
         r_s1      <= 1'b1;
         r_level   <= 1'b1;
         r_level_q <= 1'b1;
         r_cnt     <= '0;
         o_fall    <= 1'b0;
      end else begin
         r_s0      <= i_raw;
         r_s1      <= r_s0;
         r_level_q <= r_level;
         o_fall    <= r_level_q & ~r_level;
         // The FILTER_LEN-th disagreeing sample in a row flips the level.
         if (r_s1 != r_level) begin
            if (r_cnt == CNT_LAST) begin
               r_level <= r_s1;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver producing the 11-bit ps2_key event word.
// Deframes start/8 data/odd parity/stop frames on filtered clock falling
// edges, folds E0 (extended) and F0 (break) prefixes into the event, swallows
// the E1 Pause sequence and drops controller status replies.
// Ports:
//   clk_sys, reset : system clock, asynchronous active-high reset
//   ps2_clk_in     : raw PS/2 clock pin
//   ps2_data_in    : raw PS/2 data pin
//   ps2_key        : [7:0] code, [8] ext, [9] pressed, [10] event toggle
//   parity_err     : one-cycle pulse, frame failed odd parity
//   frame_err      : one-cycle pulse, bad stop bit or mid-frame timeout
// Event handshake: there is no valid/ready pair. ps2_key holds its value
// between events; each new event is marked by bit 10 inverting, and the
// consumer must sample at least once per event (events are >1 frame apart).
module ps2_key_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic [10:0] ps2_key,
   output logic        parity_err,
   output logic        frame_err
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic            w_fall;
   logic            r_data_s0;
   logic            r_data_s1;
   ps2_state_t      r_state;
   logic [2:0]      r_idx;
   logic [7:0]      r_shift;
   logic            r_par;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_byte_valid;
   logic            r_ext;
   logic            r_brk;
   logic [2:0]      r_skip;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .i_clk  (clk_sys),
      .i_rst  (reset),
      .i_raw  (ps2_clk_in),
      .o_fall (w_fall)
   );

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_data_s0    <= 1'b1;
         r_data_s1    <= 1'b1;
         r_state      <= ST_IDLE;
         r_idx        <= 3'd0;
         r_shift      <= 8'h00;
         r_par        <= 1'b0;
         r_to_cnt     <= '0;
         r_byte_valid <= 1'b0;
         r_ext        <= 1'b0;
         r_brk        <= 1'b0;
         r_skip       <= 3'd0;
         ps2_key      <= 11'h000;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         r_data_s0    <= ps2_data_in;
         r_data_s1    <= r_data_s0;
         parity_err   <= 1'b0;
         frame_err    <= 1'b0;
         r_byte_valid <= 1'b0;

         // A fall on the terminal-count cycle wins: it clears the counter.
         if (w_fall || r_state == ST_IDLE || r_to_cnt == TO_LAST)
            r_to_cnt <= '0;
         else
            r_to_cnt <= r_to_cnt + 1'b1;

         // Decode the byte accepted on the previous cycle (r_shift is stable
         // until the next frame's first data bit, many cycles away).
         if (r_byte_valid) begin
            if (r_skip != 3'd0) begin
               r_skip <= r_skip - 3'd1;
            end else if (r_shift == PS2_PAUSE) begin
               r_skip <= PAUSE_SKIP;
            end else if (r_shift == PS2_EXT) begin
               r_ext <= 1'b1;
            end else if (r_shift == PS2_BRK) begin
               r_brk <= 1'b1;
            end else if (!(is_drop(r_shift) && !r_ext && !r_brk)) begin
               ps2_key <= {~ps2_key[KEY_TOGGLE], ~r_brk, r_ext, r_shift};
               r_ext   <= 1'b0;
               r_brk   <= 1'b0;
            end
         end

         if (w_fall) begin
            case (r_state)
               ST_IDLE: begin
                  if (!r_data_s1) begin
                     r_state <= ST_DATA;
                     r_idx   <= 3'd0;
                  end
               end
               ST_DATA: begin
                  r_shift <= {r_data_s1, r_shift[7:1]};
                  r_idx   <= r_idx + 3'd1;
                  if (r_idx == 3'd7) r_state <= ST_PARITY;
               end
               ST_PARITY: begin
                  r_par   <= r_data_s1;
                  r_state <= ST_STOP;
               end
               ST_STOP: begin
                  r_state <= ST_IDLE;
                  if (!r_data_s1) begin
                     frame_err <= 1'b1;
                     r_ext     <= 1'b0;
                     r_brk     <= 1'b0;
                     r_skip    <= 3'd0;
                  end else if (^{r_shift, r_par} != 1'b1) begin
                     parity_err <= 1'b1;
                     r_ext      <= 1'b0;
                     r_brk      <= 1'b0;
                     r_skip     <= 3'd0;
                  end else begin
                     r_byte_valid <= 1'b1;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end else if (r_state != ST_IDLE && r_to_cnt == TO_LAST) begin
            r_state   <= ST_IDLE;
            frame_err <= 1'b1;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_skip    <= 3'd0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: directed frames into ps2_key_rx. Expected ps2_key events are
// pushed to exp_q by the stimulus; a forked monitor pops one entry whenever
// ps2_key changes and counts error pulses, which checkpoints compare against
// the counts the stimulus expects.
module tb_ps2_key_rx;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 2000;
   localparam int HALF        = 40;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ps2_clk_in;
   logic        ps2_data_in;
   logic [10:0] ps2_key;
   logic        parity_err;
   logic        frame_err;

   logic [10:0] exp_q[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          got_par = 0;
   int          got_frm = 0;
   int          exp_par = 0;
   int          exp_frm = 0;

   ps2_key_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_key     (ps2_key),
      .parity_err  (parity_err),
      .frame_err   (frame_err)
   );

   // ---------------- clock ----------------
   always #10 clk_sys = ~clk_sys;

   initial begin
      #5000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- driver ----------------
   task automatic send_frame(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int nbits);
      logic [10:0] f;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk_sys);
         ps2_data_in = f[i];
         repeat (HALF / 2) @(negedge clk_sys);
         ps2_clk_in = 1'b0;
         repeat (HALF) @(negedge clk_sys);
         ps2_clk_in = 1'b1;
         repeat (HALF / 2) @(negedge clk_sys);
      end
      ps2_data_in = 1'b1;
      repeat (100) @(negedge clk_sys);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 11);
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic checkpoint(input string name);
      repeat (200) @(negedge clk_sys);
      check({name, "_queue_left"}, exp_q.size(), 0);
      check({name, "_parity_cnt"}, got_par, exp_par);
      check({name, "_frame_cnt"}, got_frm, exp_frm);
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic monitor_loop();
      logic [10:0] last_key;
      logic [10:0] exp;
      logic        prev_par;
      logic        prev_frm;
      last_key = 11'h000;
      prev_par = 1'b0;
      prev_frm = 1'b0;
      forever begin
         @(negedge clk_sys);
         if (reset) begin
            last_key = ps2_key;
            prev_par = 1'b0;
            prev_frm = 1'b0;
         end else begin
            if (ps2_key !== last_key) begin
               n_chk++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL key_unexpected got=%03h exp=none", ps2_key);
               end else begin
                  exp = exp_q.pop_front();
                  if (ps2_key !== exp) begin
                     n_err++;
                     $display("FAIL key_event got=%03h exp=%03h", ps2_key, exp);
                  end
               end
               last_key = ps2_key;
            end
            if (parity_err || frame_err) begin
               n_chk++;
               if ((parity_err && frame_err) || (parity_err && prev_par) ||
                   (frame_err && prev_frm)) begin
                  n_err++;
                  $display("FAIL err_pulse_shape got=par%0b/frm%0b prev=%0b/%0b exp=single",
                           parity_err, frame_err, prev_par, prev_frm);
               end
            end
            if (parity_err) got_par++;
            if (frame_err) got_frm++;
            prev_par = parity_err;
            prev_frm = frame_err;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset       = 1'b1;
      ps2_clk_in  = 1'b1;
      ps2_data_in = 1'b1;
      fork
         monitor_loop();
      join_none
      repeat (5) @(negedge clk_sys);
      check("reset_key", ps2_key, 11'h000);
      check("reset_par", parity_err, 0);
      check("reset_frm", frame_err, 0);
      reset = 1'b0;
      repeat (10) @(negedge clk_sys);

      // Make 'A'
      exp_q.push_back(11'h61C);
      send(8'h1C);
      checkpoint("make_1c");

      // Extended break: E0 F0 75 -> one event only
      exp_q.push_back(11'h175);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      checkpoint("ext_break_75");

      // Parity error, then good break
      exp_par++;
      send_frame(8'h1C, 1'b1, 1'b0, 11);
      checkpoint("parity_bad");
      exp_q.push_back(11'h41C);
      send(8'hF0);
      send(8'h1C);
      checkpoint("break_1c");

      // Short glitch on the clock line in IDLE
      @(negedge clk_sys);
      ps2_clk_in = 1'b0;
      repeat (3) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
      checkpoint("glitch");

      // Stalled frame -> timeout
      send_frame(8'h29, 1'b0, 1'b0, 5);
      repeat (TIMEOUT_CYC + 5) @(negedge clk_sys);
      exp_frm++;
      checkpoint("timeout");
      exp_q.push_back(11'h229);
      send(8'h29);
      checkpoint("make_29");

      // Bad stop bit clears the pending E0 prefix
      send(8'hE0);
      exp_frm++;
      send_frame(8'h29, 1'b0, 1'b1, 11);
      checkpoint("bad_stop");
      exp_q.push_back(11'h629);
      send(8'h29);
      checkpoint("make_29_noext");

      // Pause sequence and an ACK are swallowed
      send(8'hE1);
      send(8'h14);
      send(8'h77);
      send(8'hE1);
      send(8'hF0);
      send(8'h14);
      send(8'hF0);
      send(8'h77);
      send(8'hFA);
      checkpoint("pause_ack");
      exp_q.push_back(11'h25A);
      send(8'h5A);
      checkpoint("make_5a");

      // Asynchronous reset mid-frame
      send_frame(8'h33, 1'b0, 1'b0, 5);
      #3 reset = 1'b1;
      #1;
      check("midreset_key", ps2_key, 11'h000);
      check("midreset_par", parity_err, 0);
      check("midreset_frm", frame_err, 0);
      ps2_clk_in  = 1'b1;
      ps2_data_in = 1'b1;
      repeat (10) @(negedge clk_sys);
      reset = 1'b0;
      exp_q.push_back(11'h616);
      send(8'h16);
      checkpoint("after_reset_16");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
